// File: rtl/serial_mod_pkg.sv
// serial_mod_pkg: shared state encoding and width helpers for the serial residue engine
package serial_mod_pkg;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int rw_of(input int m);
    return clog2(m) < 1 ? 1 : clog2(m);
  endfunction
endpackage

// File: rtl/mod_residue_step.sv
// mod_residue_step: one-bit residue update, either MSB-first (2r+b) or LSB-first (r+b*w), one conditional subtract
module mod_residue_step #(
  parameter int MOD = 7,
  parameter int RW  = 3
) (
  input  logic [RW-1:0] r,
  input  logic          b,
  input  logic [RW-1:0] w,
  input  logic          lsb,
  output logic [RW-1:0] nr
);
  localparam logic [RW:0] M = (RW+1)'(MOD);
  logic [RW:0] s;
  // both sums stay below 2*MOD, so a single subtract reduces them
  always_comb begin
    s  = lsb ? {1'b0, r} + (b ? {1'b0, w} : '0) : {r, b};
    nr = s >= M ? RW'(s - M) : s[RW-1:0];
  end
endmodule

// File: rtl/serial_mod_residue.sv
// serial_mod_residue: multi-channel framed serial residue engine with shared framing FSM
module serial_mod_residue
  import serial_mod_pkg::*;
#(
  parameter int MOD       = 7,
  parameter int CH        = 1,
  parameter int FRAME_LEN = 16,
  parameter int LSB_FIRST = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic                         sof,
  input  logic [CH-1:0]                data_in,
  output logic [CH*rw_of(MOD)-1:0]     res_live,
  output logic [CH*rw_of(MOD)-1:0]     res_out,
  output logic [CH-1:0]                div_flag,
  output logic                         out_valid,
  output logic                         busy,
  output logic                         frame_abort
);
  localparam int RW = rw_of(MOD);
  localparam logic [RW:0] M = (RW+1)'(MOD);
  localparam logic [RW-1:0] W0 = RW'(1);
  localparam logic [RW-1:0] W1 = RW'(2 % MOD);
  localparam logic [15:0] LAST = 16'(FRAME_LEN - 1);
  state_t state;
  logic [15:0] cnt;
  logic [RW-1:0] w;
  logic [RW:0] wd;
  logic [RW-1:0] w_nxt;
  logic [CH*RW-1:0] nxt;
  logic [CH-1:0] zero;
  logic accept;
  logic last;
  assign accept = in_valid & (sof | (state == RUN));
  assign last   = sof ? (FRAME_LEN == 1) : (cnt == LAST);
  assign wd     = {w, 1'b0};
  assign w_nxt  = wd >= M ? RW'(wd - M) : wd[RW-1:0];
  assign busy   = state == RUN;
  // sof restarts every channel from r=0 with weight 1
  for (genvar g = 0; g < CH; g++) begin : g_ch
    mod_residue_step #(.MOD(MOD), .RW(RW)) u_step (
      .r  (sof ? '0 : res_live[g*RW +: RW]),
      .b  (data_in[g]),
      .w  (sof ? W0 : w),
      .lsb(LSB_FIRST != 0),
      .nr (nxt[g*RW +: RW])
    );
    assign zero[g] = nxt[g*RW +: RW] == '0;
  end
  // framing FSM, shared counter/weight and registered results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      w           <= W0;
      res_live    <= '0;
      res_out     <= '0;
      div_flag    <= '0;
      out_valid   <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      out_valid   <= 1'b0;
      frame_abort <= 1'b0;
      if (accept) begin
        res_live    <= nxt;
        frame_abort <= sof & (state == RUN);
        w           <= sof ? W1 : w_nxt;
        cnt         <= sof ? 16'd1 : cnt + 16'd1;
        state       <= last ? IDLE : RUN;
        if (last) begin
          res_out   <= nxt;
          div_flag  <= zero;
          out_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_mod_residue.sv
// tb_serial_mod_residue: scoreboarded bench over four parameterisations of the residue engine
module tb_serial_mod_residue;
  typedef struct packed {logic [11:0] res; logic [3:0] div;} res_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic a_iv = 0, a_sof = 0;
  logic [3:0] a_d = '0;
  logic [11:0] a_live, a_res;
  logic [3:0] a_div;
  logic a_ov, a_busy, a_ab;
  logic b_iv = 0, b_sof = 0, b_d = 0;
  logic [2:0] b_live, b_res;
  logic b_div, b_ov, b_busy, b_ab;
  logic c_iv = 0, c_sof = 0, c_d = 0;
  logic [2:0] c_live, c_res;
  logic c_div, c_ov, c_busy, c_ab;
  logic d_iv = 0, d_sof = 0, d_d = 0;
  logic [1:0] d_live, d_res;
  logic d_div, d_ov, d_busy, d_ab;
  int n_pass = 0, n_total = 0, n_ov = 0, n_ab = 0;
  res_t exp_q[$];
  res_t e;
  serial_mod_residue #(.MOD(7), .CH(4), .FRAME_LEN(16), .LSB_FIRST(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .sof(a_sof), .data_in(a_d),
    .res_live(a_live), .res_out(a_res), .div_flag(a_div), .out_valid(a_ov),
    .busy(a_busy), .frame_abort(a_ab));
  serial_mod_residue #(.MOD(7), .CH(1), .FRAME_LEN(4), .LSB_FIRST(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .sof(b_sof), .data_in(b_d),
    .res_live(b_live), .res_out(b_res), .div_flag(b_div), .out_valid(b_ov),
    .busy(b_busy), .frame_abort(b_ab));
  serial_mod_residue #(.MOD(5), .CH(1), .FRAME_LEN(16), .LSB_FIRST(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_iv), .sof(c_sof), .data_in(c_d),
    .res_live(c_live), .res_out(c_res), .div_flag(c_div), .out_valid(c_ov),
    .busy(c_busy), .frame_abort(c_ab));
  serial_mod_residue #(.MOD(3), .CH(1), .FRAME_LEN(1), .LSB_FIRST(0)) dut_d (
    .clk(clk), .rst_n(rst_n), .in_valid(d_iv), .sof(d_sof), .data_in(d_d),
    .res_live(d_live), .res_out(d_res), .div_flag(d_div), .out_valid(d_ov),
    .busy(d_busy), .frame_abort(d_ab));
  // scoreboard: every completed frame on the 4-channel instance must match the oldest expectation
  always @(negedge clk) begin
    if (a_ab) n_ab++;
    if (a_ov) begin
      n_ov++;
      n_total++;
      if (exp_q.size() == 0) $display("FAIL sb_unexpected: got res=%h div=%b, no frame expected", a_res, a_div);
      else begin
        e = exp_q.pop_front();
        if ({a_res, a_div} !== e) $display("FAIL sb_frame: got res=%h div=%b expected res=%h div=%b", a_res, a_div, e.res, e.div);
        else n_pass++;
      end
    end
  end
  task automatic step_a(input logic s, input logic [3:0] b);
    a_iv = 1; a_sof = s; a_d = b;
    @(posedge clk); #1;
    a_iv = 0; a_sof = 0; a_d = '0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  // full-precision shift register then %7 per channel, pushed before the bits go out
  task automatic send_a(input logic [63:0] f, input int gap);
    res_t x;
    logic [63:0] sr;
    logic [63:0] r;
    logic [3:0] b;
    for (int c = 0; c < 4; c++) begin
      sr = '0;
      for (int i = 0; i < 16; i++) sr = (sr << 1) | 64'(f[c*16 + 15 - i]);
      r = sr % 64'd7;
      x.res[c*3 +: 3] = r[2:0];
      x.div[c] = r == 0;
    end
    exp_q.push_back(x);
    for (int i = 0; i < 16; i++) begin
      if (gap > 0 && $urandom_range(0, 99) < gap) idle($urandom_range(1, 3));
      for (int c = 0; c < 4; c++) b[c] = f[c*16 + 15 - i];
      step_a(i == 0, b);
    end
  endtask
  task automatic test_reset;
    @(negedge clk);
    n_total++;
    if ({a_live, a_res, a_div, a_ov, a_busy, a_ab} !== '0) $display("FAIL reset_a: got %h expected 0", {a_live, a_res, a_div, a_ov, a_busy, a_ab});
    else n_pass++;
    n_total++;
    if ({b_live, b_res, b_div, b_ov, b_busy, b_ab, c_live, c_res, c_div, c_ov, c_busy, c_ab, d_live, d_res, d_div, d_ov, d_busy, d_ab} !== '0)
      $display("FAIL reset_bcd: outputs not all zero in reset");
    else n_pass++;
    rst_n = 1;
    idle(1);
  endtask
  task automatic test_known;
    send_a({4{16'h0007}}, 0);
    @(negedge clk); #1;
    n_total++;
    if (a_ov !== 1'b1 || a_res !== 12'h000 || a_div !== 4'hF) $display("FAIL known_7: got ov=%b res=%h div=%b expected ov=1 res=000 div=1111", a_ov, a_res, a_div);
    else n_pass++;
    @(negedge clk); #1;
    n_total++;
    if (a_ov !== 1'b0 || a_busy !== 1'b0) $display("FAIL ov_pulse: got ov=%b busy=%b expected 0 0", a_ov, a_busy);
    else n_pass++;
    send_a({4{16'hFFFF}}, 0);
    @(negedge clk); #1;
    n_total++;
    if (a_res !== {4{3'd1}} || a_div !== 4'h0) $display("FAIL known_ffff: got res=%h div=%b expected res=249 div=0000", a_res, a_div);
    else n_pass++;
  endtask
  task automatic test_back_to_back;
    int n0;
    n0 = n_ov;
    send_a({4{16'hFFFF}}, 0);
    send_a({4{16'h000A}}, 0);
    @(negedge clk); #1;
    n_total++;
    if (a_res !== {4{3'd3}} || a_div !== 4'h0 || n_ov - n0 !== 2) $display("FAIL b2b: got res=%h div=%b frames=%0d expected res=6db div=0000 frames=2", a_res, a_div, n_ov - n0);
    else n_pass++;
  endtask
  task automatic test_channels;
    send_a({16'd14, 16'd9, 16'd8, 16'd7}, 0);
    @(negedge clk); #1;
    n_total++;
    if (a_res !== {3'd0, 3'd2, 3'd1, 3'd0} || a_div !== 4'b1001) $display("FAIL channels: got res=%h div=%b expected res=088 div=1001", a_res, a_div);
    else n_pass++;
  endtask
  task automatic test_abort;
    int ab0, ov0;
    logic [11:0] r1;
    step_a(1, 4'b0011);
    step_a(0, 4'b0011);
    step_a(0, 4'b0010);
    step_a(0, 4'b0011);
    step_a(0, 4'b0011);
    @(negedge clk); #1;
    n_total++;
    if (a_live !== {6'd0, 3'd3, 3'd6} || a_busy !== 1'b1) $display("FAIL live: got live=%h busy=%b expected live=01e busy=1", a_live, a_busy);
    else n_pass++;
    ab0 = n_ab;
    ov0 = n_ov;
    send_a(64'h1234_5678_9ABC_DEF0, 0);
    @(negedge clk); #1;
    r1 = a_res;
    n_total++;
    if (n_ab - ab0 !== 1 || n_ov - ov0 !== 1) $display("FAIL abort: got aborts=%0d frames=%0d expected 1 1", n_ab - ab0, n_ov - ov0);
    else n_pass++;
    send_a(64'h1234_5678_9ABC_DEF0, 40);
    @(negedge clk); #1;
    n_total++;
    if (a_res !== r1 || n_ab - ab0 !== 1 || n_ov - ov0 !== 2) $display("FAIL gaps: got res=%h aborts=%0d frames=%0d expected res=%h 1 2", a_res, n_ab - ab0, n_ov - ov0, r1);
    else n_pass++;
  endtask
  task automatic test_random;
    for (int k = 0; k < 20; k++) begin
      send_a({$urandom, $urandom}, $urandom_range(0, 30));
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
    end
    idle(2);
    n_total++;
    if (exp_q.size() !== 0) $display("FAIL random_drain: got %0d pending expected 0", exp_q.size());
    else n_pass++;
  endtask
  task automatic test_reset_mid;
    int ov0;
    send_a({4{16'hFFFF}}, 0);
    step_a(1, 4'hF);
    repeat (8) step_a(0, 4'hA);
    #1 rst_n = 0;
    #1;
    n_total++;
    if ({a_live, a_res, a_div, a_ov, a_busy, a_ab} !== '0) $display("FAIL reset_mid: got %h expected 0", {a_live, a_res, a_div, a_ov, a_busy, a_ab});
    else n_pass++;
    @(negedge clk);
    rst_n = 1;
    ov0 = n_ov;
    repeat (3) step_a(0, 4'hF);
    @(negedge clk); #1;
    n_total++;
    if (a_busy !== 1'b0 || a_live !== '0 || n_ov !== ov0) $display("FAIL no_sof: got busy=%b live=%h frames=%0d expected 0 0 0", a_busy, a_live, n_ov - ov0);
    else n_pass++;
    send_a({$urandom, $urandom}, 10);
    @(negedge clk); #1;
    n_total++;
    if (n_ov - ov0 !== 1) $display("FAIL after_reset: got frames=%0d expected 1", n_ov - ov0);
    else n_pass++;
  endtask
  task automatic test_lsb;
    logic [3:0] v4;
    logic [15:0] v16;
    v4 = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      b_iv = 1; b_sof = i == 0; b_d = v4[i];
      @(posedge clk); #1;
      b_iv = 0; b_sof = 0; b_d = 0;
    end
    @(negedge clk); #1;
    n_total++;
    if (b_ov !== 1'b1 || b_res !== 3'd3 || b_div !== 1'b0) $display("FAIL lsb_10: got ov=%b res=%0d div=%b expected 1 3 0", b_ov, b_res, b_div);
    else n_pass++;
    v4 = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      b_iv = 1; b_sof = i == 0; b_d = v4[i];
      @(posedge clk); #1;
      b_iv = 0; b_sof = 0; b_d = 0;
    end
    @(negedge clk); #1;
    n_total++;
    if (b_ov !== 1'b1 || b_res !== 3'd0 || b_div !== 1'b1) $display("FAIL lsb_7: got ov=%b res=%0d div=%b expected 1 0 1", b_ov, b_res, b_div);
    else n_pass++;
    v16 = 16'h0019;
    for (int i = 0; i < 16; i++) begin
      c_iv = 1; c_sof = i == 0; c_d = v16[i];
      @(posedge clk); #1;
      c_iv = 0; c_sof = 0; c_d = 0;
    end
    @(negedge clk); #1;
    n_total++;
    if (c_ov !== 1'b1 || c_res !== 3'd0 || c_div !== 1'b1) $display("FAIL lsb_mod5_25: got ov=%b res=%0d div=%b expected 1 0 1", c_ov, c_res, c_div);
    else n_pass++;
    v16 = 16'h8001;
    for (int i = 0; i < 16; i++) begin
      c_iv = 1; c_sof = i == 0; c_d = v16[i];
      @(posedge clk); #1;
      c_iv = 0; c_sof = 0; c_d = 0;
    end
    @(negedge clk); #1;
    n_total++;
    if (c_ov !== 1'b1 || c_res !== 3'd4 || c_div !== 1'b0) $display("FAIL lsb_mod5_8001: got ov=%b res=%0d div=%b expected 1 4 0", c_ov, c_res, c_div);
    else n_pass++;
  endtask
  task automatic test_len1;
    d_iv = 1; d_sof = 1; d_d = 1;
    @(posedge clk); #1;
    d_iv = 0; d_sof = 0; d_d = 0;
    @(negedge clk); #1;
    n_total++;
    if (d_ov !== 1'b1 || d_res !== 2'd1 || d_div !== 1'b0 || d_busy !== 1'b0) $display("FAIL len1_one: got ov=%b res=%0d div=%b busy=%b expected 1 1 0 0", d_ov, d_res, d_div, d_busy);
    else n_pass++;
    d_iv = 1; d_sof = 0; d_d = 0;
    @(posedge clk); #1;
    d_iv = 0;
    @(negedge clk); #1;
    n_total++;
    if (d_ov !== 1'b0 || d_res !== 2'd1) $display("FAIL len1_nosof: got ov=%b res=%0d expected 0 1", d_ov, d_res);
    else n_pass++;
    d_iv = 1; d_sof = 1; d_d = 0;
    @(posedge clk); #1;
    d_iv = 0; d_sof = 0;
    @(negedge clk); #1;
    n_total++;
    if (d_ov !== 1'b1 || d_res !== 2'd0 || d_div !== 1'b1) $display("FAIL len1_zero: got ov=%b res=%0d div=%b expected 1 0 1", d_ov, d_res, d_div);
    else n_pass++;
  endtask
  initial begin
    test_reset;
    test_known;
    test_back_to_back;
    test_channels;
    test_abort;
    test_random;
    test_reset_mid;
    test_lsb;
    test_len1;
    idle(2);
    n_total++;
    if (exp_q.size() !== 0) $display("FAIL final_drain: got %0d pending expected 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
